// File: rtl/epd_pkg.sv
// Shared constants and state encoding for the EPD transmit scheduler.
package epd_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  IDLE_BYTE     = 8'h00;
    localparam int unsigned PREAMBLE_LEN  = 7;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        BODY,
        DRAIN,
        IFG
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester after the last winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] pick_idx;
    logic          found;
    int unsigned   idx;

    // Scan starts one past the pointer so the last winner has lowest priority.
    always_comb begin
        grant    = '0;
        pick_idx = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[PW'(idx)]) begin
                found           = 1'b1;
                pick_idx        = PW'(idx);
                grant[PW'(idx)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= PW'(NUM_REQ - 1);
        end else if (accept && found) begin
            ptr <= pick_idx;
        end
    end

endmodule

// File: rtl/epd_tx_scheduler.sv
// Shares the byte-wide data/control link among NUM_REQ frame sources:
// preamble/SFD insertion, body streaming, abort/drain handling and IFG.
module epd_tx_scheduler
    import epd_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned IFG_CYCLES = 1,
    parameter int unsigned MAX_FRAME  = 1518
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] in_data,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [NUM_REQ-1:0]   in_last,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           data,
    output logic                 control,
    output logic                 frame_done,
    output logic                 err_underrun,
    output logic                 err_oversize,
    output logic [3:0]           tx_frame_count
);

    localparam int unsigned BW = $clog2(MAX_FRAME + 1);
    localparam int unsigned IW = $clog2(IFG_CYCLES + 1);

    localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_FRAME);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES);
    localparam logic [2:0]    PRE_LAST = 3'(PREAMBLE_LEN);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [7:0]           data_nxt;
    logic                 control_nxt;
    logic                 frame_done_nxt;
    logic                 err_underrun_nxt;
    logic                 err_oversize_nxt;
    logic [3:0]           count_nxt;
    logic [2:0]           pre_cnt, pre_cnt_nxt;
    logic [BW-1:0]        byte_cnt, byte_cnt_nxt;
    logic [IW-1:0]        ifg_cnt, ifg_cnt_nxt;

    logic [NUM_REQ-1:0]   arb_grant;
    logic                 launch;

    logic                 own_valid;
    logic                 own_last;
    logic                 own_req;
    logic [7:0]           own_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .accept (launch),
        .grant  (arb_grant)
    );

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_req   = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_valid = in_valid[i];
                own_last  = in_last[i];
                own_req   = req[i];
                own_data  = in_data[8*i +: 8];
            end
        end
    end

    assign in_ready = (state == BODY || state == DRAIN) ? grant : '0;

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        data_nxt         = data;
        control_nxt      = control;
        frame_done_nxt   = 1'b0;
        err_underrun_nxt = 1'b0;
        err_oversize_nxt = 1'b0;
        count_nxt        = tx_frame_count;
        pre_cnt_nxt      = pre_cnt;
        byte_cnt_nxt     = byte_cnt;
        ifg_cnt_nxt      = ifg_cnt;
        launch           = 1'b0;

        case (state)
            IDLE: begin
                data_nxt    = IDLE_BYTE;
                control_nxt = 1'b0;
                grant_nxt   = '0;
                launch      = |req;
            end

            PREAMBLE: begin
                if (pre_cnt == PRE_LAST) begin
                    data_nxt  = SFD_BYTE;
                    state_nxt = BODY;
                end else begin
                    data_nxt    = PREAMBLE_BYTE;
                    pre_cnt_nxt = pre_cnt + 3'd1;
                end
            end

            BODY: begin
                if (own_valid) begin
                    data_nxt     = own_data;
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    if (own_last) begin
                        frame_done_nxt = 1'b1;
                        count_nxt      = tx_frame_count + 4'd1;
                        grant_nxt      = '0;
                        ifg_cnt_nxt    = '0;
                        state_nxt      = IFG;
                    end else if (byte_cnt + 1'b1 == BYTE_MAX) begin
                        err_oversize_nxt = 1'b1;
                        state_nxt        = DRAIN;
                    end
                end else begin
                    control_nxt      = 1'b0;
                    data_nxt         = IDLE_BYTE;
                    err_underrun_nxt = 1'b1;
                    if (own_req) begin
                        state_nxt = DRAIN;
                    end else begin
                        // Link already low on this edge, so it counts as the first gap cycle.
                        grant_nxt   = '0;
                        ifg_cnt_nxt = IW'(1);
                        state_nxt   = IFG;
                    end
                end
            end

            DRAIN: begin
                control_nxt = 1'b0;
                data_nxt    = IDLE_BYTE;
                if (own_valid && own_last) begin
                    grant_nxt   = '0;
                    ifg_cnt_nxt = IW'(1);
                    state_nxt   = IFG;
                end
            end

            IFG: begin
                control_nxt = 1'b0;
                data_nxt    = IDLE_BYTE;
                grant_nxt   = '0;
                if (ifg_cnt == IFG_LAST) begin
                    launch = |req;
                    if (!launch) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ifg_cnt_nxt = ifg_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (launch) begin
            grant_nxt    = arb_grant;
            data_nxt     = PREAMBLE_BYTE;
            control_nxt  = 1'b1;
            pre_cnt_nxt  = 3'd1;
            byte_cnt_nxt = '0;
            ifg_cnt_nxt  = '0;
            state_nxt    = PREAMBLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            grant          <= '0;
            data           <= IDLE_BYTE;
            control        <= 1'b0;
            frame_done     <= 1'b0;
            err_underrun   <= 1'b0;
            err_oversize   <= 1'b0;
            tx_frame_count <= '0;
            pre_cnt        <= '0;
            byte_cnt       <= '0;
            ifg_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            grant          <= grant_nxt;
            data           <= data_nxt;
            control        <= control_nxt;
            frame_done     <= frame_done_nxt;
            err_underrun   <= err_underrun_nxt;
            err_oversize   <= err_oversize_nxt;
            tx_frame_count <= count_nxt;
            pre_cnt        <= pre_cnt_nxt;
            byte_cnt       <= byte_cnt_nxt;
            ifg_cnt        <= ifg_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_epd_tx_scheduler.sv
// Directed bench for epd_tx_scheduler (NUM_REQ=2, IFG_CYCLES=3, MAX_FRAME=70).
module tb_epd_tx_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req, in_valid, in_last, in_ready, grant;
    logic [15:0] in_data;
    logic [7:0]  data;
    logic        control, frame_done, err_underrun, err_oversize;
    logic [3:0]  tx_frame_count;

    always #5 clock = ~clock;

    epd_tx_scheduler #(
        .NUM_REQ    (2),
        .IFG_CYCLES (3),
        .MAX_FRAME  (70)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .grant          (grant),
        .data           (data),
        .control        (control),
        .frame_done     (frame_done),
        .err_underrun   (err_underrun),
        .err_oversize   (err_oversize),
        .tx_frame_count (tx_frame_count)
    );

    int tests = 0;
    int fails = 0;

    // Frame sources: seed-based byte pattern, optional one-cycle valid drop.
    int         pos[2];
    int         flen[2];
    int         nfr[2];
    int         drop_at[2];
    bit         act[2];
    bit         dropped[2];
    logic [7:0] seed[2];

    logic [7:0] cap[$];
    logic [7:0] expq[$];
    logic [1:0] grant_q[$];
    logic [1:0] prev_grant = 2'b00;
    int fd_cnt = 0, und_cnt = 0, ovs_cnt = 0;
    int low_run = 0, last_gap = -1, gmin = 999, gmax = 0;
    bit fd_since_rise = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] qget(input int k);
        if (k < int'(grant_q.size())) return grant_q[k];
        return 2'bxx;
    endfunction

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            req[i]            = act[i];
            in_valid[i]       = act[i] && !(pos[i] == drop_at[i] && !dropped[i]);
            in_last[i]        = act[i] && (pos[i] == flen[i] - 1);
            in_data[8*i +: 8] = seed[i] + 8'(pos[i]);
        end
    endtask

    task automatic load(input int i, input logic [7:0] s, input int l, input int n, input int d);
        seed[i]    = s;
        flen[i]    = l;
        nfr[i]     = n;
        drop_at[i] = d;
        pos[i]     = 0;
        act[i]     = 1'b1;
        dropped[i] = 1'b0;
    endtask

    task automatic exp_frame(input int i, input int n);
        for (int k = 0; k < 7; k++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
        for (int k = 0; k < n; k++) expq.push_back(seed[i] + 8'(k));
    endtask

    task automatic step();
        logic [1:0] hs, stall;
        hs    = in_ready & in_valid;
        stall = in_ready & ~in_valid;
        @(posedge clock);
        #1;
        if (control === 1'b1) begin
            cap.push_back(data);
            if (low_run > 0) begin
                if (fd_since_rise) begin
                    last_gap = low_run;
                    if (low_run < gmin) gmin = low_run;
                    if (low_run > gmax) gmax = low_run;
                end
                fd_since_rise = 1'b0;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_since_rise = 1'b1;
        end
        if (err_underrun === 1'b1) und_cnt++;
        if (err_oversize === 1'b1) ovs_cnt++;
        if (grant !== prev_grant && grant !== 2'b00) grant_q.push_back(grant);
        prev_grant = grant;
        for (int i = 0; i < 2; i++) begin
            if (stall[i]) dropped[i] = 1'b1;
            if (hs[i]) begin
                if (pos[i] == flen[i] - 1) begin
                    pos[i] = 0;
                    nfr[i]--;
                    if (nfr[i] == 0) act[i] = 1'b0;
                end else begin
                    pos[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_fd(input int tgt, input string tag);
        for (int n = 0; n < 2000 && fd_cnt < tgt; n++) step();
        chk(tag, fd_cnt, tgt);
    endtask

    task automatic cmp_stream(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_len"}, cap.size(), expq.size());
        for (int k = 0; k < int'(cap.size()) && k < int'(expq.size()); k++) begin
            if (cap[k] !== expq[k]) mism++;
        end
        chk({tag, "_bytes"}, mism, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; flen[i] = 1; nfr[i] = 0; drop_at[i] = -1;
            act[i] = 1'b0; dropped[i] = 1'b0; seed[i] = 8'h00;
        end
        req = '0; in_valid = '0; in_last = '0; in_data = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_control", control, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_ready", in_ready, 2'b00);
        chk("rst_count", tx_frame_count, 4'd0);
        chk("rst_pulses", {frame_done, err_underrun, err_oversize}, 3'b000);
        reset = 1'b1;
        idle(2);

        // Single 64-byte frame from req0
        cap.delete(); expq.delete();
        load(0, 8'h10, 64, 1, -1); drive(); exp_frame(0, 64);
        step();
        chk("sf_grant", grant, 2'b01);
        chk("sf_ctl", control, 1'b1);
        chk("sf_pre1", data, 8'h55);
        chk("sf_ready_pre", in_ready, 2'b00);
        repeat (6) step();
        chk("sf_pre7", data, 8'h55);
        step();
        chk("sf_sfd", data, 8'hD5);
        chk("sf_ready", in_ready, 2'b01);
        repeat (64) step();
        chk("sf_last", data, 8'h4F);
        chk("sf_fd", frame_done, 1'b1);
        chk("sf_cnt", tx_frame_count, 4'd1);
        chk("sf_grant_clr", grant, 2'b00);
        step();
        chk("sf_ifg_ctl", control, 1'b0);
        chk("sf_fd_once", frame_done, 1'b0);
        idle(6);
        chk("sf_fd_total", fd_cnt, 1);
        cmp_stream("sf_stream");

        // Simultaneous requests: last winner was req0, so req1 goes first
        cap.delete(); expq.delete(); grant_q.delete();
        load(0, 8'h20, 20, 1, -1); load(1, 8'h40, 24, 1, -1); drive();
        exp_frame(1, 24); exp_frame(0, 20);
        wait_fd(3, "sim_done");
        chk("sim_first", qget(0), 2'b10);
        chk("sim_second", qget(1), 2'b01);
        chk("sim_gap", last_gap, 3);
        chk("sim_cnt", tx_frame_count, 4'd3);
        idle(6);
        cmp_stream("sim_stream");

        grant_q.delete();
        load(0, 8'h60, 16, 1, -1); load(1, 8'h70, 16, 1, -1); drive();
        wait_fd(5, "rot_done");
        chk("rot_first", qget(0), 2'b10);
        chk("rot_second", qget(1), 2'b01);
        chk("rot_cnt", tx_frame_count, 4'd5);
        idle(6);

        // Underrun at body byte 20
        cap.delete(); expq.delete();
        load(0, 8'hA0, 40, 1, 19); drive(); exp_frame(0, 19);
        for (int n = 0; n < 200 && err_underrun !== 1'b1; n++) step();
        chk("und_pulse", err_underrun, 1'b1);
        chk("und_ctl", control, 1'b0);
        chk("und_data", data, 8'h00);
        chk("und_ready", in_ready, 2'b01);
        chk("und_cnt", tx_frame_count, 4'd5);
        for (int n = 0; n < 200 && act[0]; n++) step();
        chk("und_drained", act[0], 1'b0);
        idle(6);
        chk("und_total", und_cnt, 1);
        chk("und_no_fd", fd_cnt, 5);
        cmp_stream("und_stream");

        // Oversize: 80-byte frame against MAX_FRAME=70
        cap.delete(); expq.delete();
        load(1, 8'h80, 80, 1, -1); drive(); exp_frame(1, 70);
        for (int n = 0; n < 200 && err_oversize !== 1'b1; n++) step();
        chk("ovs_pulse", err_oversize, 1'b1);
        chk("ovs_ctl", control, 1'b1);
        chk("ovs_data", data, 8'hC5);
        chk("ovs_und_quiet", err_underrun, 1'b0);
        repeat (9) step();
        chk("ovs_drain_grant", grant, 2'b10);
        chk("ovs_drain_ctl", control, 1'b0);
        chk("ovs_drain_ready", in_ready, 2'b10);
        step();
        chk("ovs_end_grant", grant, 2'b00);
        idle(20);
        chk("ovs_total", ovs_cnt, 1);
        chk("ovs_cnt", tx_frame_count, 4'd5);
        cmp_stream("ovs_stream");

        // Counter wrap: 11 more back-to-back frames bring the total to 16
        gmin = 999; gmax = 0;
        load(0, 8'h01, 8, 6, -1); load(1, 8'h90, 8, 5, -1); drive();
        wait_fd(15, "wrap_ten");
        chk("wrap_15", tx_frame_count, 4'd15);
        wait_fd(16, "wrap_eleven");
        chk("wrap_0", tx_frame_count, 4'd0);
        chk("wrap_gap_min", gmin, 3);
        chk("wrap_gap_max", gmax, 3);
        idle(6);

        // Reset in the middle of a body
        cap.delete();
        load(0, 8'hC0, 64, 1, -1); load(1, 8'hE0, 64, 1, -1); drive();
        for (int n = 0; n < 300 && cap.size() < 38; n++) step();
        chk("rmb_reach", cap.size(), 38);
        reset = 1'b0;
        #1;
        chk("rmb_data", data, 8'h00);
        chk("rmb_ctl", control, 1'b0);
        chk("rmb_grant", grant, 2'b00);
        chk("rmb_ready", in_ready, 2'b00);
        pos[0] = 0; pos[1] = 0; drive();
        step(); step();
        chk("rmb_hold_ctl", control, 1'b0);
        chk("rmb_count", tx_frame_count, 4'd0);
        chk("rmb_no_pulse", {und_cnt, ovs_cnt, fd_cnt}, {32'd1, 32'd1, 32'd16});
        reset = 1'b1;
        cap.delete(); expq.delete(); grant_q.delete();
        exp_frame(0, 64); exp_frame(1, 64);
        step();
        chk("rmb_regrant", grant, 2'b01);
        chk("rmb_pre", data, 8'h55);
        wait_fd(18, "rmb_done");
        chk("rmb_cnt2", tx_frame_count, 4'd2);
        chk("rmb_second", qget(1), 2'b10);
        idle(6);
        cmp_stream("rmb_stream");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
